// File: rtl/mux_pkg.sv
// Shared types and constants for the registered nibble multiplexer family.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [3:0] nibble_t;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage : mux_pkg

// File: rtl/mux2_comb.sv
// Purely combinational 2-to-1 word selector, built bit by bit from AND/OR terms
// so the gate-level structure is visible in the netlist.
module mux2_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a0,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y[gi] = (sel & a1[gi]) | (~sel & a0[gi]);
    end
  endgenerate

endmodule : mux2_comb

// File: rtl/four_bit_2x1_mux_reg.sv
// Registered 2-to-1 word multiplexer: selection is combinational, the result
// and a "captured since reset" flag are registered on the rising clock edge.
module four_bit_2x1_mux_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In_1,
  input  logic [WIDTH-1:0] In_0,
  input  logic             Select,
  output logic [WIDTH-1:0] Out,
  output logic             Out_valid
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("four_bit_2x1_mux_reg: WIDTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] out_reg;
  logic             out_valid_reg;

  mux2_comb #(
    .WIDTH (WIDTH)
  ) u_mux2_comb (
    .a1  (In_1),
    .a0  (In_0),
    .sel (Select),
    .y   (sel_word)
  );

  // Reset clears immediately so a mid-stream word is discarded without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_reg       <= sel_word;
      out_valid_reg <= 1'b1;
    end
  end

  assign Out       = out_reg;
  assign Out_valid = out_valid_reg;

endmodule : four_bit_2x1_mux_reg

// File: tb/tb_four_bit_2x1_mux_reg.sv
// Directed self-checking bench for four_bit_2x1_mux_reg at WIDTH = 4.
module tb_four_bit_2x1_mux_reg;
  import mux_pkg::*;

  logic    clk;
  logic    rst_n;
  nibble_t in_1;
  nibble_t in_0;
  logic    select;
  nibble_t out_word;
  logic    out_valid;

  int errors = 0;
  int checks = 0;

  four_bit_2x1_mux_reg #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In_1      (in_1),
    .In_0      (in_0),
    .Select    (select),
    .Out       (out_word),
    .Out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Apply inputs, clock once, sample 1 ns after the edge.
  task automatic step(input logic s, input nibble_t a1, input nibble_t a0);
    select = s;
    in_1   = a1;
    in_0   = a0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nibble_t exp_word;
    nibble_t held;

    rst_n  = 1'b0;
    select = SEL_IN1;
    in_1   = 4'hF;
    in_0   = 4'hA;

    // Reset held across several edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_out", {4'h0, out_word}, 8'h00);
      check("rst_valid", {7'h0, out_valid}, 8'h00);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_out", {4'h0, out_word}, 8'h0F);
    check("rel_valid", {7'h0, out_valid}, 8'h01);

    // Exhaustive sweep.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          exp_word = (s == 1) ? 4'(a) : 4'(b);
          step(s[0], 4'(a), 4'(b));
          check("sweep", {4'h0, out_word}, {4'h0, exp_word});
        end
      end
    end
    check("sweep_valid", {7'h0, out_valid}, 8'h01);

    // Select toggling every cycle.
    for (int i = 0; i < 8; i++) begin
      step(i[0], 4'h5, 4'hA);
      check("toggle", {4'h0, out_word}, i[0] ? 8'h05 : 8'h0A);
    end

    // Activity on the unselected bus must not leak through.
    for (int i = 0; i < 8; i++) begin
      step(SEL_IN0, 4'($urandom_range(0, 15)), 4'h3);
      check("unsel", {4'h0, out_word}, 8'h03);
    end

    // Inputs changing between edges leave Out untouched until the next edge.
    step(SEL_IN1, 4'hC, 4'h1);
    check("glitch_pre", {4'h0, out_word}, 8'h0C);
    held = out_word;
    #1 select = SEL_IN0;
    #1 in_0 = 4'h7;
    #1;
    check("glitch_mid", {4'h0, out_word}, {4'h0, held});
    @(posedge clk);
    #1;
    check("glitch_post", {4'h0, out_word}, 8'h07);

    // Asynchronous reset between edges.
    step(SEL_IN1, 4'h9, 4'h2);
    check("async_pre", {4'h0, out_word}, 8'h09);
    #2 rst_n = 1'b0;
    #1;
    check("async_out", {4'h0, out_word}, 8'h00);
    check("async_valid", {7'h0, out_valid}, 8'h00);
    @(posedge clk);
    #1;
    check("async_hold", {4'h0, out_word}, 8'h00);
    #2 rst_n = 1'b1;
    step(SEL_IN1, 4'h6, 4'h2);
    check("resume_out", {4'h0, out_word}, 8'h06);
    check("resume_valid", {7'h0, out_valid}, 8'h01);
    step(SEL_IN0, 4'h6, 4'hB);
    check("resume_sel0", {4'h0, out_word}, 8'h0B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_four_bit_2x1_mux_reg
